// File: rtl/mix_round_engine_if.sv
// mix_round_engine_if: seed/result valid-ready channels of the mixing engine.
interface mix_round_engine_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*WIDTH-1:0] out_data;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/mix_round_engine.sv
// mix_round_engine: iterative LANES x WIDTH mixer, one full round per clock, valid/ready job handshake.
// Define MIX_FINAL_MUL_EN to add the FINAL per-lane multiply state between RUN and DONE.
module mix_round_engine #(
   parameter int WIDTH  = 32,
   parameter int LANES  = 8,
   parameter int ROUNDS = 8,
   parameter int SHL    = 16,
   parameter int SHR_A  = 17,
   parameter int SHR_B  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   mix_round_engine_if.slave bus,
   output logic              busy,
   output logic [7:0]        round_cnt
);
   localparam int IW = $clog2(LANES);
   typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;
   typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;
   state_t state;
   lanes_t lanes;
   logic   ready;
   logic   valid;
   assign bus.in_ready  = ready;
   assign bus.out_valid = valid;
   assign bus.out_data  = lanes;
   function automatic logic [IW-1:0] idx(int k);
      return IW'(k % LANES);
   endfunction
   // Each pass walks the lanes in order, so later lanes see values already updated in this pass.
   function automatic lanes_t mix(lanes_t v);
      lanes_t o = v;
      for (int i = 0; i < LANES; i++)
         o[idx(i)] = o[idx(i)] + o[idx(i + 1)] - o[idx(i + 5)];
      for (int i = 0; i < LANES; i++)
         o[idx(i)] = o[idx(i)] ^ (o[idx(i + 3)] << SHL);
      for (int i = 0; i < LANES; i++)
         o[idx(i)] = o[idx(i)] - (o[idx(i + 2)] >> SHR_A) + (o[idx(i + 4)] >> SHR_B);
      return o;
   endfunction
`ifdef MIX_FINAL_MUL_EN
   function automatic lanes_t fin(lanes_t v);
      lanes_t o;
      for (int i = 0; i < LANES; i++)
         o[idx(i)] = v[idx(i)] * WIDTH'(2 * i + 3) + WIDTH'(i * i);
      return o;
   endfunction
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lanes     <= '0;
         ready     <= 1'b0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         round_cnt <= 8'd0;
      end else if (flush) begin
         state     <= IDLE;
         ready     <= 1'b1;
         valid     <= 1'b0;
         busy      <= 1'b0;
         round_cnt <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && ready) begin
                  lanes     <= bus.in_data;
                  round_cnt <= 8'd0;
                  state     <= RUN;
                  ready     <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  ready <= 1'b1;
               end
            end
            RUN: begin
               lanes     <= mix(lanes);
               round_cnt <= round_cnt + 8'd1;
               if (round_cnt == 8'(ROUNDS - 1)) begin
`ifdef MIX_FINAL_MUL_EN
                  state <= FINAL;
`else
                  state <= DONE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
`endif
               end
            end
`ifdef MIX_FINAL_MUL_EN
            FINAL: begin
               lanes <= fin(lanes);
               state <= DONE;
               busy  <= 1'b0;
               valid <= 1'b1;
            end
`endif
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mix_round_engine.sv
// tb_mix_round_engine: directed checks of two engine instances (ROUNDS=1 and ROUNDS=8).
// Honours MIX_FINAL_MUL_EN by expecting the extra FINAL cycle and per-lane multiply.
module tb_mix_round_engine;
   typedef logic [7:0][31:0] lanes_t;
`ifdef MIX_FINAL_MUL_EN
   localparam bit FM = 1'b1;
`else
   localparam bit FM = 1'b0;
`endif
   localparam int XL = FM ? 1 : 0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush1 = 1'b0;
   logic flush8 = 1'b0;
   logic busy1, busy8;
   logic [7:0] rc1, rc8;
   int checks = 0;
   int failures = 0;
   mix_round_engine_if #(.WIDTH(32), .LANES(8)) b1 ();
   mix_round_engine_if #(.WIDTH(32), .LANES(8)) b8 ();
   mix_round_engine #(.WIDTH(32), .LANES(8), .ROUNDS(1)) d1 (
      .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(b1.slave), .busy(busy1), .round_cnt(rc1));
   mix_round_engine #(.WIDTH(32), .LANES(8), .ROUNDS(8)) d8 (
      .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(b8.slave), .busy(busy8), .round_cnt(rc8));
   always #5 clk = ~clk;
   function automatic lanes_t fin(lanes_t v);
      lanes_t o;
      for (int i = 0; i < 8; i++) o[i] = v[i] * (2 * i + 3) + i * i;
      return o;
   endfunction
   function automatic lanes_t model(lanes_t s, int rounds, bit fm);
      lanes_t o = s;
      repeat (rounds) begin
         for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i + 1) & 7] - o[(i + 5) & 7];
         for (int i = 0; i < 8; i++) o[i] ^= o[(i + 3) & 7] << 16;
         for (int i = 0; i < 8; i++) o[i] = o[i] - (o[(i + 2) & 7] >> 17) + (o[(i + 4) & 7] >> 12);
      end
      return fm ? fin(o) : o;
   endfunction
   // Waits for in_ready, submits one seed, returns edges from accept to out_valid (-1 on timeout).
   task automatic job(input bit big, input lanes_t seed, output int lat, output lanes_t res);
      int n = 0;
      while (!(big ? b8.in_ready : b1.in_ready) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (big) begin b8.in_valid = 1'b1; b8.in_data = seed; end
      else begin b1.in_valid = 1'b1; b1.in_data = seed; end
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
      b8.in_valid = 1'b0;
      lat = 0;
      while (!(big ? b8.out_valid : b1.out_valid) && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!(big ? b8.out_valid : b1.out_valid) || n >= 20) lat = -1;
      res = big ? b8.out_data : b1.out_data;
   endtask
   task automatic consume(input bit big);
      if (big) b8.out_ready = 1'b1; else b1.out_ready = 1'b1;
      @(posedge clk); #1;
      b1.out_ready = 1'b0;
      b8.out_ready = 1'b0;
   endtask
   task automatic test_reset();
      #2;
      checks++;
      if ({b1.in_ready, b1.out_valid, busy1, b8.in_ready, b8.out_valid, busy8} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got %b want 000000", {b1.in_ready, b1.out_valid, busy1, b8.in_ready, b8.out_valid, busy8});
      end
      checks++;
      if (rc1 !== 8'd0 || rc8 !== 8'd0) begin
         failures++; $display("FAIL reset_round_cnt got %0d/%0d want 0/0", rc1, rc8);
      end
      checks++;
      if (b1.out_data !== '0 || b8.out_data !== '0) begin
         failures++; $display("FAIL reset_lanes got %h want 0", b1.out_data | b8.out_data);
      end
      #10 rst_n = 1'b1;
      #2;
      checks++;
      if (b1.in_ready !== 1'b0 || b8.in_ready !== 1'b0) begin
         failures++; $display("FAIL ready_before_edge got %b%b want 00", b1.in_ready, b8.in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (b1.in_ready !== 1'b1 || b8.in_ready !== 1'b1) begin
         failures++; $display("FAIL ready_after_edge got %b%b want 11", b1.in_ready, b8.in_ready);
      end
   endtask
   task automatic test_zero_seed();
      int lat;
      lanes_t res, exp;
      for (int i = 0; i < 8; i++) exp[i] = FM ? i * i : 0;
      job(1'b0, '0, lat, res);
      checks++;
      if (lat !== 1 + XL) begin failures++; $display("FAIL zero_latency got %0d want %0d", lat, 1 + XL); end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL zero_data got %h want %h", res, exp); end
      checks++;
      if (rc1 !== 8'd1 || busy1 !== 1'b0) begin
         failures++; $display("FAIL zero_done_status got cnt=%0d busy=%b want cnt=1 busy=0", rc1, busy1);
      end
      consume(1'b0);
      checks++;
      if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
         failures++; $display("FAIL zero_release got valid=%b ready=%b want 0/1", b1.out_valid, b1.in_ready);
      end
   endtask
   task automatic test_impulse();
      int lat;
      lanes_t res, seed, exp;
      lanes_t t2 = {32'h000F7FF1, 32'hFFFF8002, 32'h0010FFF8, 32'h0010FFF0,
                    32'hFFFEFFFF, 32'h00000000, 32'hFFFF8011, 32'hFFFF0011};
      seed = '0;
      seed[0] = 32'd1;
      exp = FM ? fin(t2) : t2;
      job(1'b0, seed, lat, res);
      checks++;
      if (lat !== 1 + XL) begin failures++; $display("FAIL impulse_latency got %0d want %0d", lat, 1 + XL); end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL impulse_data got %h want %h", res, exp); end
      consume(1'b0);
   endtask
   task automatic test_stall();
      int lat;
      int bad = 0;
      lanes_t res, exp;
      lanes_t s = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0BADF00D,
                   32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF, 32'h80000001};
      exp = model(s, 8, FM);
      job(1'b1, s, lat, res);
      checks++;
      if (lat !== 8 + XL) begin failures++; $display("FAIL stall_latency got %0d want %0d", lat, 8 + XL); end
      checks++;
      if (res !== exp) begin failures++; $display("FAIL stall_data got %h want %h", res, exp); end
      repeat (20) begin
         @(posedge clk); #1;
         if (b8.out_valid !== 1'b1 || b8.out_data !== exp) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
      checks++;
      if (rc8 !== 8'd8) begin failures++; $display("FAIL stall_round_cnt got %0d want 8", rc8); end
      consume(1'b1);
      checks++;
      if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || busy8 !== 1'b0) begin
         failures++;
         $display("FAIL stall_release got valid=%b ready=%b busy=%b want 0/1/0", b8.out_valid, b8.in_ready, busy8);
      end
   endtask
   task automatic test_flush();
      int lat;
      int bad = 0;
      lanes_t res;
      lanes_t s2 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                    32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
      lanes_t s3 = {32'h0, 32'h0, 32'h0, 32'hCAFEBABE, 32'h0, 32'h0, 32'h00000100, 32'h0};
      b8.in_valid = 1'b1;
      b8.in_data = s2;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (rc8 !== 8'd3 || busy8 !== 1'b1) begin
         failures++; $display("FAIL flush_pre got cnt=%0d busy=%b want 3/1", rc8, busy8);
      end
      flush8 = 1'b1;
      @(posedge clk); #1;
      flush8 = 1'b0;
      checks++;
      if (b8.in_ready !== 1'b1 || rc8 !== 8'd0 || busy8 !== 1'b0 || b8.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle got ready=%b cnt=%0d busy=%b valid=%b want 1/0/0/0", b8.in_ready, rc8, busy8, b8.out_valid);
      end
      checks++;
      if (b8.out_data !== model(s2, 3, 1'b0)) begin
         failures++; $display("FAIL flush_lanes got %h want %h", b8.out_data, model(s2, 3, 1'b0));
      end
      repeat (12) begin
         @(posedge clk); #1;
         if (b8.out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL flush_no_valid got %0d valid cycles want 0", bad); end
      b8.in_valid = 1'b1;
      b8.in_data = s3;
      flush8 = 1'b1;
      @(posedge clk); #1;
      flush8 = 1'b0;
      b8.in_valid = 1'b0;
      checks++;
      if (busy8 !== 1'b0 || b8.in_ready !== 1'b1) begin
         failures++; $display("FAIL flush_beats_accept got busy=%b ready=%b want 0/1", busy8, b8.in_ready);
      end
      job(1'b1, s3, lat, res);
      checks++;
      if (lat !== 8 + XL || res !== model(s3, 8, FM)) begin
         failures++; $display("FAIL flush_rerun got lat=%0d %h want lat=%0d %h", lat, res, 8 + XL, model(s3, 8, FM));
      end
      consume(1'b1);
   endtask
   task automatic test_async_reset();
      int lat;
      lanes_t res;
      lanes_t s4 = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0,
                    32'h00FF00FF, 32'hFF00FF00, 32'h12345678, 32'h9ABCDEF0};
      lanes_t s5 = {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'hFFFF0000};
      b8.in_valid = 1'b1;
      b8.in_data = s4;
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({b8.in_ready, b8.out_valid, busy8} !== 3'b0 || rc8 !== 8'd0 || b8.out_data !== '0) begin
         failures++;
         $display("FAIL async_reset got ready=%b valid=%b busy=%b cnt=%0d data=%h want all 0",
                  b8.in_ready, b8.out_valid, busy8, rc8, b8.out_data);
      end
      #10 rst_n = 1'b1;
      job(1'b1, s5, lat, res);
      checks++;
      if (lat !== 8 + XL || res !== model(s5, 8, FM)) begin
         failures++; $display("FAIL async_rerun got lat=%0d %h want lat=%0d %h", lat, res, 8 + XL, model(s5, 8, FM));
      end
      consume(1'b1);
   endtask
   task automatic test_back_to_back();
      int lat;
      lanes_t res;
      lanes_t sa = {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
      lanes_t sb = {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};
      b1.out_ready = 1'b1;
      job(1'b0, sa, lat, res);
      checks++;
      if (lat !== 1 + XL || res !== model(sa, 1, FM)) begin
         failures++; $display("FAIL b2b_first got lat=%0d %h want lat=%0d %h", lat, res, 1 + XL, model(sa, 1, FM));
      end
      @(posedge clk); #1;
      checks++;
      if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_turnaround got valid=%b ready=%b want 0/1", b1.out_valid, b1.in_ready);
      end
      job(1'b0, sb, lat, res);
      checks++;
      if (lat !== 1 + XL || res !== model(sb, 1, FM)) begin
         failures++; $display("FAIL b2b_second got lat=%0d %h want lat=%0d %h", lat, res, 1 + XL, model(sb, 1, FM));
      end
      b1.out_ready = 1'b0;
   endtask
   initial begin
      b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
      b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
      test_reset();
      test_zero_seed();
      test_impulse();
      test_stall();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end
endmodule
